// File: rtl/layer_tile_controller_if.sv
// layer_tile_controller_if: groups the controller's host, SRAM, buffer, PE and index signals
// Latency: none, wiring only
// Backpressure: none of its own; master drives the controller inputs, slave is the controller side
interface layer_tile_controller_if #(
  parameter int IDX_W   = 896,
  parameter int BUF_AW  = 6,
  parameter int SRAM_AW = 16,
  parameter int TILE_W  = 8
);
  // controller inputs
  logic               start;
  logic [TILE_W-1:0]  num_tiles;
  logic               empty;
  logic               dispatcher_done;
  logic               zcip_done;
  logic               pe_done;
  logic               index_en;
  logic [IDX_W-1:0]   index_in;

  // controller outputs
  logic               sram_en;
  logic [SRAM_AW-1:0] sram_w_rd_addr;
  logic [SRAM_AW-1:0] sram_a_rd_addr;
  logic [SRAM_AW-1:0] sram_wr_addr;
  logic               sram_wr_en;
  logic               buf_wr_en;
  logic [BUF_AW-1:0]  buf_w_wr_addr;
  logic [BUF_AW-1:0]  buf_a_wr_addr;
  logic [BUF_AW-1:0]  buf_w_rd_addr;
  logic [BUF_AW-1:0]  buf_a_rd_addr;
  logic               buf_rd_en;
  logic               sign_en;
  logic [1:0]         acc_en;
  logic [IDX_W-1:0]   index_vector;
  logic               index_ready;
  logic               index_ovf;
  logic               busy;
  logic               done;
  logic [31:0]        perf_busy_cyc;
  logic [31:0]        perf_stall_cyc;

  modport master (
    output start, num_tiles, empty, dispatcher_done, zcip_done, pe_done, index_en, index_in,
    input  sram_en, sram_w_rd_addr, sram_a_rd_addr, sram_wr_addr, sram_wr_en,
           buf_wr_en, buf_w_wr_addr, buf_a_wr_addr, buf_w_rd_addr, buf_a_rd_addr, buf_rd_en,
           sign_en, acc_en, index_vector, index_ready, index_ovf, busy, done,
           perf_busy_cyc, perf_stall_cyc
  );

  modport slave (
    input  start, num_tiles, empty, dispatcher_done, zcip_done, pe_done, index_en, index_in,
    output sram_en, sram_w_rd_addr, sram_a_rd_addr, sram_wr_addr, sram_wr_en,
           buf_wr_en, buf_w_wr_addr, buf_a_wr_addr, buf_w_rd_addr, buf_a_rd_addr, buf_rd_en,
           sign_en, acc_en, index_vector, index_ready, index_ovf, busy, done,
           perf_busy_cyc, perf_stall_cyc
  );
endinterface

// File: rtl/layer_tile_controller.sv
// layer_tile_controller: per-tile sequencer (SRAM fetch, buffer fill, dispatch, compute, writeback) with ping-pong index banks
// Latency: at least 6 cycles per tile plus one DONE cycle; a zero-tile layer goes IDLE->DONE->IDLE
// Backpressure: holds in FETCH_SRAM while empty, in each wait state until its done strobe; index writes while both banks are full are dropped and flag index_ovf
// Optional feature macro: LAYER_CTRL_PERF_CNT_EN enables the busy/stall performance counters
module layer_tile_controller #(
  parameter int IDX_W   = 896,
  parameter int BUF_AW  = 6,
  parameter int SRAM_AW = 16,
  parameter int TILE_W  = 8
) (
  input logic                    clk,
  input logic                    rst,
  layer_tile_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH_SRAM, UPDATE_BUF, FETCH_DATA, DISPATCH, COMPUTE, WRITEBACK, DONE
  } state_t;

  state_t state, state_next;

  logic [SRAM_AW-1:0] sram_w_rd_cnt, sram_a_rd_cnt, sram_wr_cnt;
  logic [BUF_AW-1:0]  buf_w_wr_addr_q, buf_a_wr_addr_q, buf_rd_cnt;
  logic [TILE_W-1:0]  tile_cnt, num_tiles_q;
  logic [IDX_W-1:0]   bank [2];
  logic [1:0]         bank_vld, bank_vld_next;
  logic               wr_ptr, rd_ptr;
  logic               index_ovf_q;

  logic start_ok, fetch_go, disp_go, pe_go, last_tile;
  logic bank_any, index_ready, index_wr;

  logic       sram_en, sram_wr_en, buf_wr_en, buf_rd_en, sign_en, busy, done;
  logic [1:0] acc_en;

  assign bank_any    = |bank_vld;
  assign index_ready = ~&bank_vld;
  assign index_wr    = bus.index_en & index_ready;
  assign last_tile   = (tile_cnt == num_tiles_q - TILE_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and per-state output strobes
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    fetch_go   = 1'b0;
    disp_go    = 1'b0;
    pe_go      = 1'b0;
    sram_en    = 1'b0;
    sram_wr_en = 1'b0;
    buf_wr_en  = 1'b0;
    buf_rd_en  = 1'b0;
    sign_en    = 1'b0;
    acc_en     = 2'b00;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.start) begin
          start_ok   = 1'b1;
          state_next = (bus.num_tiles != '0) ? FETCH_SRAM : DONE;
        end
      end
      FETCH_SRAM: begin
        sram_en = 1'b1;
        if (!bus.empty) begin
          fetch_go   = 1'b1;
          state_next = UPDATE_BUF;
        end
      end
      UPDATE_BUF: begin
        buf_wr_en  = 1'b1;
        state_next = FETCH_DATA;
      end
      FETCH_DATA: begin
        buf_rd_en = 1'b1;
        if (bus.dispatcher_done) begin
          disp_go    = 1'b1;
          state_next = DISPATCH;
        end
      end
      DISPATCH: begin
        sign_en = 1'b1;
        if (bus.zcip_done && bank_any) state_next = COMPUTE;
      end
      COMPUTE: begin
        acc_en = 2'b11;
        if (bus.pe_done) begin
          pe_go      = 1'b1;
          state_next = WRITEBACK;
        end
      end
      WRITEBACK: begin
        sram_wr_en = 1'b1;
        state_next = last_tile ? DONE : FETCH_SRAM;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address counters, tile count and the layer's sampled tile total
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_w_rd_cnt   <= '0;
      sram_a_rd_cnt   <= '0;
      sram_wr_cnt     <= '0;
      buf_w_wr_addr_q <= '0;
      buf_a_wr_addr_q <= '0;
      buf_rd_cnt      <= '0;
      tile_cnt        <= '0;
      num_tiles_q     <= '0;
    end else begin
      if (start_ok) begin
        tile_cnt    <= '0;
        num_tiles_q <= bus.num_tiles;
      end else if (state == WRITEBACK && !last_tile) begin
        tile_cnt <= tile_cnt + TILE_W'(1);
      end
      if (fetch_go) begin
        // buffer write address is the address the SRAM word was read from
        buf_w_wr_addr_q <= sram_w_rd_cnt[BUF_AW-1:0];
        buf_a_wr_addr_q <= sram_a_rd_cnt[BUF_AW-1:0];
        sram_w_rd_cnt   <= sram_w_rd_cnt + SRAM_AW'(1);
        sram_a_rd_cnt   <= sram_a_rd_cnt + SRAM_AW'(1);
      end
      if (disp_go) buf_rd_cnt <= buf_rd_cnt + BUF_AW'(1);
      if (state == WRITEBACK) sram_wr_cnt <= sram_wr_cnt + SRAM_AW'(1);
    end
  end

  // Bank valid update: compute's release and a new write may land in the same cycle
  always_comb begin
    bank_vld_next = bank_vld;
    if (pe_go)    bank_vld_next[rd_ptr] = 1'b0;
    if (index_wr) bank_vld_next[wr_ptr] = 1'b1;
  end

  // Ping-pong index banks and their pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_vld <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      bank[0]  <= '0;
      bank[1]  <= '0;
    end else begin
      bank_vld <= bank_vld_next;
      if (index_wr) begin
        bank[wr_ptr] <= bus.index_in;
        wr_ptr       <= ~wr_ptr;
      end
      if (pe_go) rd_ptr <= ~rd_ptr;
    end
  end

  // Sticky drop flag; a drop in the same cycle as a start keeps it set
  always_ff @(posedge clk) begin
    if (rst)                              index_ovf_q <= 1'b0;
    else if (bus.index_en && !index_ready) index_ovf_q <= 1'b1;
    else if (start_ok)                    index_ovf_q <= 1'b0;
  end

`ifdef LAYER_CTRL_PERF_CNT_EN
  logic [31:0] perf_busy_q, perf_stall_q;
  logic        stall_now;

  assign stall_now = (state == FETCH_SRAM && bus.empty) || (state == DISPATCH && !bank_any);

  // Saturating busy and stall cycle counters, cleared per layer
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy && perf_busy_q != 32'hFFFF_FFFF)       perf_busy_q  <= perf_busy_q + 32'd1;
      if (stall_now && perf_stall_q != 32'hFFFF_FFFF) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_busy_cyc  = perf_busy_q;
  assign bus.perf_stall_cyc = perf_stall_q;
`else
  assign bus.perf_busy_cyc  = 32'd0;
  assign bus.perf_stall_cyc = 32'd0;
`endif

  assign bus.sram_en        = sram_en;
  assign bus.sram_w_rd_addr = sram_w_rd_cnt;
  assign bus.sram_a_rd_addr = sram_a_rd_cnt;
  assign bus.sram_wr_addr   = sram_wr_cnt;
  assign bus.sram_wr_en     = sram_wr_en;
  assign bus.buf_wr_en      = buf_wr_en;
  assign bus.buf_w_wr_addr  = buf_w_wr_addr_q;
  assign bus.buf_a_wr_addr  = buf_a_wr_addr_q;
  assign bus.buf_w_rd_addr  = buf_rd_cnt;
  assign bus.buf_a_rd_addr  = buf_rd_cnt;
  assign bus.buf_rd_en      = buf_rd_en;
  assign bus.sign_en        = sign_en;
  assign bus.acc_en         = acc_en;
  assign bus.index_vector   = (state == COMPUTE) ? bank[rd_ptr] : '0;
  assign bus.index_ready    = index_ready;
  assign bus.index_ovf      = index_ovf_q;
  assign bus.busy           = busy;
  assign bus.done           = done;

endmodule

// File: tb/tb_layer_tile_controller.sv
// tb_layer_tile_controller: directed tests for the layer tile controller
// A default-size instance covers the main flow; a 7-bit SRAM address instance covers counter wrap
// Strobes are driven from the bench tasks, one cycle after the consuming state is entered
module tb_layer_tile_controller;
  localparam int IDX_W     = 896;
  localparam int BUF_AW    = 6;
  localparam int SRAM_AW   = 16;
  localparam int TILE_W    = 8;
  localparam int S_IDX_W   = 32;
  localparam int S_SRAM_AW = 7;

  localparam logic [IDX_W-1:0] V0 = {28{32'hA5A5_0001}};
  localparam logic [IDX_W-1:0] V1 = {28{32'h5A5A_0002}};
  localparam logic [IDX_W-1:0] V2 = {28{32'h0F0F_0003}};
  localparam logic [IDX_W-1:0] V3 = {28{32'hC3C3_0004}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_tile_controller_if #(.IDX_W(IDX_W), .BUF_AW(BUF_AW), .SRAM_AW(SRAM_AW), .TILE_W(TILE_W)) bus ();
  layer_tile_controller_if #(.IDX_W(S_IDX_W), .BUF_AW(BUF_AW), .SRAM_AW(S_SRAM_AW), .TILE_W(TILE_W)) sbus ();

  layer_tile_controller #(.IDX_W(IDX_W), .BUF_AW(BUF_AW), .SRAM_AW(SRAM_AW), .TILE_W(TILE_W))
    dut (.clk(clk), .rst(rst), .bus(bus));
  layer_tile_controller #(.IDX_W(S_IDX_W), .BUF_AW(BUF_AW), .SRAM_AW(S_SRAM_AW), .TILE_W(TILE_W))
    u_small (.clk(clk), .rst(rst), .bus(sbus));

  int total = 0;
  int bad   = 0;

  logic auto_strb, prev_rd, prev_sign, prev_acc;
  int   wr_cnt, done_cnt, sram_en_cnt, feed_cnt;
  logic [IDX_W-1:0]   feed_vec;
  logic [SRAM_AW-1:0] wr_addrs[$];
  logic [IDX_W-1:0]   vecs[$];
  logic [S_SRAM_AW-1:0] s_fetch[$];
  logic [BUF_AW-1:0]    s_bw[$];
  logic [BUF_AW-1:0]    s_ba[$];

  task automatic clear_log();
    wr_cnt = 0; done_cnt = 0; sram_en_cnt = 0; feed_cnt = 0;
    prev_rd = 0; prev_sign = 0; prev_acc = 0; auto_strb = 0;
    wr_addrs.delete(); vecs.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 0; bus.num_tiles = '0; bus.empty = 0; bus.dispatcher_done = 0;
    bus.zcip_done = 0; bus.pe_done = 0; bus.index_en = 0; bus.index_in = '0;
    sbus.start = 0; sbus.num_tiles = '0; sbus.empty = 0; sbus.dispatcher_done = 0;
    sbus.zcip_done = 0; sbus.pe_done = 0; sbus.index_en = 0; sbus.index_in = '0;
    clear_log();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // one cycle: observe outputs at the falling edge, then set the next strobes
  task automatic step();
    @(negedge clk);
    if (bus.sram_wr_en) begin wr_cnt++; wr_addrs.push_back(bus.sram_wr_addr); end
    if (bus.done) done_cnt++;
    if (bus.sram_en) sram_en_cnt++;
    if (bus.acc_en == 2'b11 && !prev_acc) vecs.push_back(bus.index_vector);
    bus.dispatcher_done = auto_strb && bus.buf_rd_en && prev_rd;
    bus.zcip_done       = auto_strb && bus.sign_en && prev_sign;
    bus.pe_done         = auto_strb && (bus.acc_en == 2'b11) && prev_acc;
    prev_rd   = bus.buf_rd_en;
    prev_sign = bus.sign_en;
    prev_acc  = (bus.acc_en == 2'b11);
    if (feed_cnt > 0 && bus.index_ready) begin
      bus.index_en = 1; bus.index_in = feed_vec; feed_cnt--;
    end else begin
      bus.index_en = 0;
    end
  endtask

  task automatic finish_layer(input int budget, input string name);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin step(); c++; end
    total++;
    if (done_cnt == 0) begin bad++; $display("FAIL %s_timeout: no done within %0d cycles", name, budget); end
    repeat (2) step();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.busy, bus.done, bus.sram_en, bus.sram_wr_en, bus.buf_wr_en, bus.buf_rd_en,
         bus.sign_en, bus.acc_en, bus.index_ready, bus.index_ovf} !== 11'b00000000010) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000000010", {bus.busy, bus.done, bus.sram_en,
        bus.sram_wr_en, bus.buf_wr_en, bus.buf_rd_en, bus.sign_en, bus.acc_en, bus.index_ready, bus.index_ovf});
    end
    total++;
    if ({bus.sram_w_rd_addr, bus.sram_a_rd_addr, bus.sram_wr_addr, bus.buf_w_wr_addr,
         bus.buf_a_wr_addr, bus.buf_w_rd_addr, bus.buf_a_rd_addr} !== '0) begin
      bad++; $display("FAIL reset_addr: sram_wr_addr=%h sram_w_rd_addr=%h buf_w_rd_addr=%h want all 0",
                      bus.sram_wr_addr, bus.sram_w_rd_addr, bus.buf_w_rd_addr);
    end
    total++;
    if (bus.index_vector !== '0) begin bad++; $display("FAIL reset_vec: low word %h want 0", bus.index_vector[31:0]); end
    total++;
    if ({bus.perf_busy_cyc, bus.perf_stall_cyc} !== 64'd0) begin
      bad++; $display("FAIL reset_perf: busy=%0d stall=%0d want 0", bus.perf_busy_cyc, bus.perf_stall_cyc);
    end
  endtask

  task automatic test_three_tiles();
    logic [IDX_W-1:0] exp_v[3];
    exp_v[0] = V0; exp_v[1] = V1; exp_v[2] = V2;
    do_reset();
    bus.index_en = 1; bus.index_in = V0; @(negedge clk);
    bus.index_in = V1; @(negedge clk);
    bus.index_en = 0;
    total++;
    if (bus.index_ready !== 1'b0) begin bad++; $display("FAIL preload_full: index_ready=%b want 0", bus.index_ready); end
    auto_strb = 1; feed_vec = V2; feed_cnt = 1;
    bus.start = 1; bus.num_tiles = 8'd3; step();
    bus.start = 0; bus.num_tiles = 8'd7;
    finish_layer(200, "three_tiles");
    total++;
    if (wr_cnt !== 3) begin bad++; $display("FAIL tiles_wb_count: got %0d want 3", wr_cnt); end
    for (int i = 0; i < wr_addrs.size() && i < 3; i++) begin
      total++;
      if (wr_addrs[i] !== SRAM_AW'(i)) begin bad++; $display("FAIL tiles_wb_addr%0d: got %h want %h", i, wr_addrs[i], i); end
    end
    for (int i = 0; i < vecs.size() && i < 3; i++) begin
      total++;
      if (vecs[i] !== exp_v[i]) begin bad++; $display("FAIL tiles_vec%0d: low word %h want %h", i, vecs[i][31:0], exp_v[i][31:0]); end
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL tiles_done_count: got %0d want 1", done_cnt); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL tiles_busy_after: got %b want 0", bus.busy); end
    total++;
`ifdef LAYER_CTRL_PERF_CNT_EN
    if (bus.perf_busy_cyc !== 32'd28) begin bad++; $display("FAIL tiles_perf_busy: got %0d want 28", bus.perf_busy_cyc); end
`else
    if (bus.perf_busy_cyc !== 32'd0) begin bad++; $display("FAIL tiles_perf_busy: got %0d want 0", bus.perf_busy_cyc); end
`endif
  endtask

  task automatic test_zero_tiles();
    clear_log();
    bus.num_tiles = 8'd0; bus.start = 1; step();
    bus.start = 0;
    total++;
    if ({bus.done, bus.busy} !== 2'b11) begin bad++; $display("FAIL zero_done_pulse: done,busy=%b want 11", {bus.done, bus.busy}); end
    step();
    total++;
    if ({bus.done, bus.busy} !== 2'b00) begin bad++; $display("FAIL zero_back_idle: done,busy=%b want 00", {bus.done, bus.busy}); end
    step();
    total++;
    if (sram_en_cnt !== 0 || wr_cnt !== 0 || done_cnt !== 1) begin
      bad++; $display("FAIL zero_no_sram: sram_en=%0d wr=%0d done=%0d want 0 0 1", sram_en_cnt, wr_cnt, done_cnt);
    end
  endtask

  task automatic test_index_overflow();
    do_reset();
    bus.index_en = 1; bus.index_in = V1; @(negedge clk);
    total++;
    if (bus.index_ready !== 1'b1) begin bad++; $display("FAIL ovf_ready_one: index_ready=%b want 1", bus.index_ready); end
    bus.index_in = V3; @(negedge clk);
    total++;
    if ({bus.index_ready, bus.index_ovf} !== 2'b00) begin bad++; $display("FAIL ovf_full: ready,ovf=%b want 00", {bus.index_ready, bus.index_ovf}); end
    bus.index_in = V2; @(negedge clk);
    bus.index_en = 0;
    total++;
    if ({bus.index_ready, bus.index_ovf} !== 2'b01) begin bad++; $display("FAIL ovf_drop: ready,ovf=%b want 01", {bus.index_ready, bus.index_ovf}); end
    auto_strb = 1;
    bus.start = 1; bus.num_tiles = 8'd2; step();
    bus.start = 0;
    total++;
    if (bus.index_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear_on_start: got %b want 0", bus.index_ovf); end
    finish_layer(100, "ovf_drain");
    total++;
    if (vecs.size() !== 2) begin bad++; $display("FAIL ovf_vec_count: got %0d want 2", vecs.size()); end
    else if (vecs[0] !== V1 || vecs[1] !== V3) begin
      bad++; $display("FAIL ovf_bank_hold: got %h,%h want %h,%h", vecs[0][31:0], vecs[1][31:0], V1[31:0], V3[31:0]);
    end
  endtask

  task automatic test_stall();
    int held = 0;
    do_reset();
    bus.index_en = 1; bus.index_in = V0; @(negedge clk);
    bus.index_en = 0;
    auto_strb = 1; bus.empty = 1;
    bus.start = 1; bus.num_tiles = 8'd1; step();
    bus.start = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.sram_en && !bus.buf_wr_en) held++;
      step();
    end
    total++;
    if (held !== 10) begin bad++; $display("FAIL stall_hold: got %0d cycles in fetch want 10", held); end
    bus.empty = 0;
    finish_layer(100, "stall");
    total++;
    if (wr_cnt !== 1) begin bad++; $display("FAIL stall_wb_count: got %0d want 1", wr_cnt); end
    total++;
`ifdef LAYER_CTRL_PERF_CNT_EN
    if (bus.perf_stall_cyc !== 32'd10) begin bad++; $display("FAIL stall_perf: got %0d want 10", bus.perf_stall_cyc); end
`else
    if (bus.perf_stall_cyc !== 32'd0) begin bad++; $display("FAIL stall_perf: got %0d want 0", bus.perf_stall_cyc); end
`endif
  endtask

  task automatic test_reset_mid();
    int c = 0;
    do_reset();
    bus.index_en = 1; bus.index_in = V2; @(negedge clk);
    bus.index_en = 0;
    auto_strb = 1;
    bus.start = 1; bus.num_tiles = 8'd1; step();
    bus.start = 0;
    while (bus.acc_en !== 2'b11 && c < 50) begin step(); c++; end
    total++;
    if (bus.acc_en !== 2'b11) begin bad++; $display("FAIL mid_reach_compute: acc_en=%b want 11", bus.acc_en); end
    rst = 1; auto_strb = 0;
    bus.dispatcher_done = 0; bus.zcip_done = 0; bus.pe_done = 0;
    @(negedge clk);
    rst = 0;
    total++;
    if ({bus.acc_en, bus.busy, bus.sign_en, bus.index_ready} !== 5'b00001) begin
      bad++; $display("FAIL mid_ctrl: acc,busy,sign,ready=%b want 00001", {bus.acc_en, bus.busy, bus.sign_en, bus.index_ready});
    end
    total++;
    if (bus.index_vector !== '0) begin bad++; $display("FAIL mid_vec: low word %h want 0", bus.index_vector[31:0]); end
    total++;
    if ({bus.sram_w_rd_addr, bus.sram_a_rd_addr, bus.buf_w_wr_addr, bus.buf_w_rd_addr} !== '0) begin
      bad++; $display("FAIL mid_counters: sram_rd=%h buf_wr=%h buf_rd=%h want 0", bus.sram_w_rd_addr, bus.buf_w_wr_addr, bus.buf_w_rd_addr);
    end
  endtask

  task automatic small_layer(input int n, input int budget);
    int  c = 0;
    bit  seen = 0;
    s_fetch.delete(); s_bw.delete(); s_ba.delete();
    sbus.start = 1; sbus.num_tiles = TILE_W'(n);
    while (!seen && c < budget) begin
      @(negedge clk);
      sbus.start = 0; c++;
      if (sbus.sram_en) s_fetch.push_back(sbus.sram_w_rd_addr);
      if (sbus.buf_wr_en) begin s_bw.push_back(sbus.buf_w_wr_addr); s_ba.push_back(sbus.buf_a_wr_addr); end
      if (sbus.done) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL wrap_layer%0d_timeout: no done within %0d cycles", n, budget); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    sbus.dispatcher_done = 1; sbus.zcip_done = 1; sbus.pe_done = 1;
    sbus.index_en = 1; sbus.index_in = 32'h1234_5678;
    small_layer(126, 1200);
    total++;
    if (s_fetch.size() !== 126) begin bad++; $display("FAIL wrap_first_fetches: got %0d want 126", s_fetch.size()); end
    small_layer(2, 100);
    total++;
    if (s_fetch.size() !== 2 || s_bw.size() !== 2) begin
      bad++; $display("FAIL wrap_two_count: fetch=%0d bufwr=%0d want 2 2", s_fetch.size(), s_bw.size());
    end else begin
      total++;
      if (s_fetch[0] !== 7'h7E || s_fetch[1] !== 7'h7F) begin
        bad++; $display("FAIL wrap_sram_rd: got %h,%h want 7e,7f", s_fetch[0], s_fetch[1]);
      end
      total++;
      if (s_bw[0] !== 6'h3E || s_bw[1] !== 6'h3F || s_ba[1] !== 6'h3F) begin
        bad++; $display("FAIL wrap_buf_wr: got %h,%h,%h want 3e,3f,3f", s_bw[0], s_bw[1], s_ba[1]);
      end
    end
    total++;
    if ({sbus.sram_w_rd_addr, sbus.sram_a_rd_addr, sbus.sram_wr_addr} !== '0) begin
      bad++; $display("FAIL wrap_to_zero: w=%h a=%h wr=%h want 0 0 0", sbus.sram_w_rd_addr, sbus.sram_a_rd_addr, sbus.sram_wr_addr);
    end
    small_layer(1, 100);
    total++;
    if (s_fetch.size() !== 1 || s_ba.size() !== 1) begin
      bad++; $display("FAIL wrap_after_count: fetch=%0d bufwr=%0d want 1 1", s_fetch.size(), s_ba.size());
    end else if (s_fetch[0] !== 7'h00 || s_ba[0] !== 6'h00 || s_bw[0] !== 6'h00) begin
      bad++; $display("FAIL wrap_after_addr: sram=%h buf_a=%h buf_w=%h want 0 0 0", s_fetch[0], s_ba[0], s_bw[0]);
    end
  endtask

  initial begin
    test_reset();
    test_three_tiles();
    test_zero_tiles();
    test_index_overflow();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
